// File: rtl/multicycle_ctrl.sv
// Control FSM for the multicycle RV32I datapath: fetch/decode/execute/memory/writeback sequencing.
// Optional feature macro CTRL_PERF_EN adds cycle_cnt and instret_cnt performance counters.
module multicycle_ctrl #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instruction,
    input  logic        imem_ready,
    input  logic        dmem_ready,
    input  logic        branch_taken,
    output logic        imem_req,
    output logic        ir_we,
    output logic        imm_en,
    output logic        alu_bsel,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic        reg_we,
    output logic [1:0]  wb_sel,
    output logic        pc_we,
    output logic [1:0]  pc_sel,
    output logic        illegal,
    output logic [2:0]  state
`ifdef CTRL_PERF_EN
    ,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
`endif
);

    localparam int unsigned WAIT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    localparam logic [4:0] OP_LD    = 5'b00000;
    localparam logic [4:0] OP_OPI   = 5'b00100;
    localparam logic [4:0] OP_AUIPC = 5'b00101;
    localparam logic [4:0] OP_ST    = 5'b01000;
    localparam logic [4:0] OP_OP    = 5'b01100;
    localparam logic [4:0] OP_LUI   = 5'b01101;
    localparam logic [4:0] OP_BR    = 5'b11000;
    localparam logic [4:0] OP_JALR  = 5'b11001;
    localparam logic [4:0] OP_JAL   = 5'b11011;

    typedef enum logic [2:0] {
        ST_BOOT   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_TRAP   = 3'd6
    } state_e;

    state_e            state_q;
    logic [4:0]        op_q;
    logic [WAIT_W-1:0] wait_q;
    logic              unused_s;

    function automatic logic op_legal(input logic [4:0] op);
        logic ok;
        case (op)
            OP_LD, OP_OPI, OP_AUIPC, OP_ST, OP_OP,
            OP_LUI, OP_BR, OP_JALR, OP_JAL: ok = 1'b1;
            default:                        ok = 1'b0;
        endcase
        return ok;
    endfunction

    assign unused_s = ^{instruction[31:7], 1'(CNT_W % 2)};

    // State, opcode latch and memory wait counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_BOOT;
            op_q    <= 5'd0;
            wait_q  <= '0;
        end else begin
            case (state_q)
                ST_BOOT: begin
                    state_q <= ST_FETCH;
                    wait_q  <= '0;
                end
                ST_FETCH: begin
                    if (imem_ready) begin
                        op_q <= instruction[6:2];
                        if (op_legal(instruction[6:2]) && (instruction[1:0] == 2'b11)) begin
                            state_q <= ST_DECODE;
                        end else begin
                            state_q <= ST_TRAP;
                        end
                    end else if (wait_q == WAIT_LAST) begin
                        state_q <= ST_TRAP;
                    end else begin
                        wait_q <= wait_q + WAIT_W'(1);
                    end
                end
                ST_DECODE: state_q <= ST_EXEC;
                ST_EXEC: begin
                    wait_q <= '0;
                    if (op_q == OP_BR) begin
                        state_q <= ST_FETCH;
                    end else if ((op_q == OP_LD) || (op_q == OP_ST)) begin
                        state_q <= ST_MEM;
                    end else begin
                        state_q <= ST_WB;
                    end
                end
                ST_MEM: begin
                    if (dmem_ready) begin
                        wait_q <= '0;
                        if (op_q == OP_ST) begin
                            state_q <= ST_FETCH;
                        end else begin
                            state_q <= ST_WB;
                        end
                    end else if (wait_q == WAIT_LAST) begin
                        state_q <= ST_TRAP;
                    end else begin
                        wait_q <= wait_q + WAIT_W'(1);
                    end
                end
                ST_WB: begin
                    state_q <= ST_FETCH;
                    wait_q  <= '0;
                end
                ST_TRAP: state_q <= ST_TRAP;
                default: state_q <= ST_TRAP;
            endcase
        end
    end

    // Output decode from registered state and latched opcode; BOOT and TRAP drive no strobes
    always_comb begin
        imem_req = 1'b0;
        ir_we    = 1'b0;
        imm_en   = 1'b0;
        alu_bsel = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        reg_we   = 1'b0;
        wb_sel   = 2'b00;
        pc_we    = 1'b0;
        pc_sel   = 2'b00;
        illegal  = 1'b0;
        case (state_q)
            ST_FETCH: begin
                imem_req = 1'b1;
                ir_we    = imem_ready;
            end
            ST_DECODE: imm_en = 1'b1;
            ST_EXEC: begin
                alu_bsel = !((op_q == OP_OP) || (op_q == OP_BR));
                if (op_q == OP_BR) begin
                    pc_we  = 1'b1;
                    pc_sel = branch_taken ? 2'b01 : 2'b00;
                end else begin
                    pc_we  = 1'b0;
                end
            end
            ST_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (op_q == OP_ST);
                if (dmem_ready && (op_q == OP_ST)) begin
                    pc_we = 1'b1;
                end else begin
                    pc_we = 1'b0;
                end
            end
            ST_WB: begin
                reg_we = 1'b1;
                pc_we  = 1'b1;
                case (op_q)
                    OP_LD:           wb_sel = 2'b01;
                    OP_LUI:          wb_sel = 2'b11;
                    OP_JAL, OP_JALR: wb_sel = 2'b10;
                    default:         wb_sel = 2'b00;
                endcase
                case (op_q)
                    OP_JAL:  pc_sel = 2'b01;
                    OP_JALR: pc_sel = 2'b10;
                    default: pc_sel = 2'b00;
                endcase
            end
            ST_TRAP: illegal = 1'b1;
            default: illegal = 1'b0;
        endcase
    end

    assign state = state_q;

`ifdef CTRL_PERF_EN
    logic [CNT_W-1:0] cycle_q;
    logic [CNT_W-1:0] instret_q;

    // Free-running activity counters, wrapping naturally at 2^CNT_W
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_q   <= '0;
            instret_q <= '0;
        end else begin
            if ((state_q != ST_BOOT) && (state_q != ST_TRAP)) begin
                cycle_q <= cycle_q + CNT_W'(1);
            end
            if (pc_we) begin
                instret_q <= instret_q + CNT_W'(1);
            end
        end
    end

    assign cycle_cnt   = cycle_q;
    assign instret_cnt = instret_q;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed scenarios plus random legal instruction streams
// compared cycle by cycle against an expected-trace model built from the instruction's class.
module tb_multicycle_ctrl;

    localparam int TIMEOUT = 16;

    typedef struct packed {
        logic       imem_req;
        logic       ir_we;
        logic       imm_en;
        logic       alu_bsel;
        logic       dmem_req;
        logic       dmem_we;
        logic       reg_we;
        logic [1:0] wb_sel;
        logic       pc_we;
        logic [1:0] pc_sel;
        logic       illegal;
        logic [2:0] state;
    } outs_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instruction;
    logic        imem_ready, dmem_ready, branch_taken;
    logic        imem_req, ir_we, imm_en, alu_bsel, dmem_req, dmem_we, reg_we, pc_we, illegal;
    logic [1:0]  wb_sel, pc_sel;
    logic [2:0]  state;
`ifdef CTRL_PERF_EN
    logic [3:0]  cycle_cnt, instret_cnt;
`endif
    outs_t       act;

    int n_checks = 0;
    int n_pass   = 0;

    multicycle_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .instruction(instruction),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready), .branch_taken(branch_taken),
        .imem_req(imem_req), .ir_we(ir_we), .imm_en(imm_en), .alu_bsel(alu_bsel),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .reg_we(reg_we), .wb_sel(wb_sel),
        .pc_we(pc_we), .pc_sel(pc_sel), .illegal(illegal), .state(state)
`ifdef CTRL_PERF_EN
        , .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
`endif
    );

    assign act = {imem_req, ir_we, imm_en, alu_bsel, dmem_req, dmem_we, reg_we,
                  wb_sel, pc_we, pc_sel, illegal, state};

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic outs_t mk(input logic [2:0] st);
        outs_t e;
        e = '0;
        e.state = st;
        if (st == 3'd6) e.illegal = 1'b1;
        return e;
    endfunction

    // Drive one cycle of inputs, compare outputs mid-cycle, end just after the next rising edge.
    task automatic step(input string tag, input logic [31:0] ins, input logic ir, input logic dr,
                        input logic bt, input outs_t exp);
        instruction  = ins;
        imem_ready   = ir;
        dmem_ready   = dr;
        branch_taken = bt;
        @(negedge clk);
        check_eq(tag, 32'(act), 32'(exp));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check_eq("reset_outputs", 32'(act), 32'(mk(3'd0)));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step("boot", $urandom, 1'($urandom), 1'($urandom), 1'($urandom), mk(3'd0));
    endtask

    // Reference model: expected per-cycle trace derived from the instruction class and wait counts.
    task automatic run_instr(input logic [31:0] ins, input int iw, input int dw, input logic bt);
        logic [4:0] op;
        logic       legal;
        outs_t      e;
        op    = ins[6:2];
        legal = (ins[1:0] == 2'b11) &&
                (op inside {5'b00000, 5'b00100, 5'b00101, 5'b01000, 5'b01100,
                            5'b01101, 5'b11000, 5'b11001, 5'b11011});
        for (int k = 0; k < iw; k++) begin
            e = mk(3'd1); e.imem_req = 1'b1;
            step("fetch_wait", $urandom, 1'b0, 1'($urandom), 1'($urandom), e);
        end
        e = mk(3'd1); e.imem_req = 1'b1; e.ir_we = 1'b1;
        step("fetch_accept", ins, 1'b1, 1'($urandom), 1'($urandom), e);
        if (!legal) return;
        e = mk(3'd2); e.imm_en = 1'b1;
        step("decode", $urandom, 1'($urandom), 1'($urandom), 1'($urandom), e);
        e = mk(3'd3);
        e.alu_bsel = !(op == 5'b01100 || op == 5'b11000);
        if (op == 5'b11000) begin
            e.pc_we  = 1'b1;
            e.pc_sel = bt ? 2'b01 : 2'b00;
            step("exec_branch", $urandom, 1'($urandom), 1'($urandom), bt, e);
            return;
        end
        step("exec", $urandom, 1'($urandom), 1'($urandom), 1'($urandom), e);
        if (op == 5'b00000 || op == 5'b01000) begin
            for (int k = 0; k < dw; k++) begin
                e = mk(3'd4); e.dmem_req = 1'b1; e.dmem_we = (op == 5'b01000);
                step("mem_wait", $urandom, 1'($urandom), 1'b0, 1'($urandom), e);
            end
            e = mk(3'd4); e.dmem_req = 1'b1; e.dmem_we = (op == 5'b01000);
            e.pc_we = (op == 5'b01000);
            step("mem_done", $urandom, 1'($urandom), 1'b1, 1'($urandom), e);
            if (op == 5'b01000) return;
        end
        e = mk(3'd5); e.reg_we = 1'b1; e.pc_we = 1'b1;
        if (op == 5'b00000)                        e.wb_sel = 2'b01;
        else if (op == 5'b01101)                   e.wb_sel = 2'b11;
        else if (op == 5'b11011 || op == 5'b11001) e.wb_sel = 2'b10;
        else                                       e.wb_sel = 2'b00;
        if (op == 5'b11011)      e.pc_sel = 2'b01;
        else if (op == 5'b11001) e.pc_sel = 2'b10;
        else                     e.pc_sel = 2'b00;
        step("wb", $urandom, 1'($urandom), 1'($urandom), 1'($urandom), e);
    endtask

    task automatic expect_trap(input int cycles);
        for (int k = 0; k < cycles; k++) begin
            step("trap_hold", $urandom, 1'($urandom), 1'($urandom), 1'($urandom), mk(3'd6));
        end
    endtask

    logic [4:0] legal_ops [9] = '{5'b00000, 5'b00100, 5'b00101, 5'b01000, 5'b01100,
                                  5'b01101, 5'b11000, 5'b11001, 5'b11011};

    initial begin
        outs_t      e;
        logic [31:0] r;
        int          iw;
        rst_n = 1'b0; instruction = 32'd0;
        imem_ready = 1'b0; dmem_ready = 1'b0; branch_taken = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset_state", 32'(act), 32'(mk(3'd0)));
        rst_n = 1'b1;
        step("boot", 32'd0, 1'b1, 1'b1, 1'b1, mk(3'd0));

        run_instr(32'h00500093, 0, 0, 1'b0);
        run_instr(32'h00208463, 0, 0, 1'b1);
        run_instr(32'h00208463, 2, 0, 1'b0);
        run_instr(32'h0000a103, 0, 3, 1'b0);
        run_instr(32'h00112023, TIMEOUT - 1, TIMEOUT - 1, 1'b0);
        run_instr(32'h0000a103, 1, TIMEOUT - 1, 1'b0);

        for (int n = 0; n < 150; n++) begin
            r  = $urandom;
            iw = ($urandom_range(0, 9) == 0) ? TIMEOUT - 1 : int'($urandom_range(0, 3));
            run_instr({r[31:7], legal_ops[$urandom_range(0, 8)], 2'b11}, iw,
                      int'($urandom_range(0, 4)), 1'($urandom));
        end

        // Reset asserted while a load waits in MEM
        step("mr_fetch", 32'h0000a103, 1'b1, 1'b0, 1'b0, '{imem_req: 1'b1, ir_we: 1'b1, state: 3'd1, default: '0});
        step("mr_decode", 32'd0, 1'b0, 1'b0, 1'b0, '{imm_en: 1'b1, state: 3'd2, default: '0});
        step("mr_exec", 32'd0, 1'b0, 1'b0, 1'b0, '{alu_bsel: 1'b1, state: 3'd3, default: '0});
        dmem_ready = 1'b0;
        @(negedge clk);
        check_eq("mr_dmem_req", 32'(dmem_req), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("mr_async_clear", 32'(act), 32'(mk(3'd0)));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step("mr_boot", 32'd0, 1'b0, 1'b0, 1'b0, mk(3'd0));
        run_instr(32'h00500093, 0, 0, 1'b0);

`ifdef CTRL_PERF_EN
        do_reset();
        check_eq("perf_cycle_reset", 32'(cycle_cnt), 32'd0);
        check_eq("perf_instret_reset", 32'(instret_cnt), 32'd0);
        for (int n = 0; n < 20; n++) run_instr(32'h00500093, 0, 0, 1'b0);
        check_eq("perf_instret_wrap", 32'(instret_cnt), 32'd4);
        check_eq("perf_cycle_wrap", 32'(cycle_cnt), 32'd0);
`endif

        // Illegal opcode traps and stays trapped
        do_reset();
        run_instr(32'h0000007F, 0, 0, 1'b0);
        expect_trap(50);

        // Legal opcode with bad low bits
        do_reset();
        run_instr(32'h00500090, 1, 0, 1'b0);
        expect_trap(5);

        // Fetch never answered
        do_reset();
        for (int k = 0; k < TIMEOUT; k++) begin
            e = mk(3'd1); e.imem_req = 1'b1;
            step("fetch_timeout_wait", $urandom, 1'b0, 1'($urandom), 1'($urandom), e);
        end
        expect_trap(10);

        // Data access never answered
        do_reset();
        step("mt_fetch", 32'h00112023, 1'b1, 1'b0, 1'b0, '{imem_req: 1'b1, ir_we: 1'b1, state: 3'd1, default: '0});
        step("mt_decode", 32'd0, 1'b0, 1'b0, 1'b0, '{imm_en: 1'b1, state: 3'd2, default: '0});
        step("mt_exec", 32'd0, 1'b0, 1'b0, 1'b0, '{alu_bsel: 1'b1, state: 3'd3, default: '0});
        for (int k = 0; k < TIMEOUT; k++) begin
            step("mem_timeout_wait", $urandom, 1'($urandom), 1'b0, 1'($urandom),
                 '{dmem_req: 1'b1, dmem_we: 1'b1, state: 3'd4, default: '0});
        end
        expect_trap(10);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
